// File: rtl/cmd_sequencer.sv
// Audioport command/playback sequencer: command handshake with wait states,
// play/stop control, sample tick generation and ABUF double-buffer sequencing.
module cmd_sequencer #(
   parameter int CMD_WAIT_STATES   = 25,
   parameter int AUDIO_BUFFER_SIZE = 42,
   parameter int DIV_W             = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cmd_valid_in,
   input  logic [7:0]                           cmd_in,
   output logic                                 cmd_ready_out,
   input  logic [DIV_W-1:0]                     clk_div_in,
   output logic                                 play_out,
   output logic                                 tick_out,
   output logic                                 clr_out,
   output logic                                 cfg_out,
   output logic                                 level_out,
   output logic                                 abuf_sel_out,
   output logic [$clog2(AUDIO_BUFFER_SIZE)-1:0] abuf_idx_out,
   output logic                                 irq_out,
   output logic                                 cmd_err_out
);

   localparam int IDX_W  = $clog2(AUDIO_BUFFER_SIZE);
   localparam int WAIT_W = $clog2(CMD_WAIT_STATES + 1);

   typedef enum logic {STOPPED = 1'b0, PLAYING = 1'b1} play_state_t;

   play_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              sel_q, sel_d;
   logic              clr_q, clr_d;
   logic              cfg_q, cfg_d;
   logic              level_q, level_d;
   logic              irq_q, irq_d;
   logic              err_q, err_d;

   logic busy, accept, tick, legal;
   logic is_nop, is_clr, is_cfg, is_start, is_stop, is_level;

   assign busy   = (wait_q != '0);
   assign accept = cmd_valid_in && !busy;
   assign tick   = (state_q == PLAYING) && (cnt_q == div_q - DIV_W'(1));

   assign is_nop   = (cmd_in == 8'h00);
   assign is_clr   = (cmd_in == 8'h01);
   assign is_cfg   = (cmd_in == 8'h02);
   assign is_start = (cmd_in == 8'h04);
   assign is_stop  = (cmd_in == 8'h08);
   assign is_level = (cmd_in == 8'h10);
   assign legal    = is_nop | is_clr | is_cfg | is_start | is_stop | is_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= STOPPED;
         wait_q  <= '0;
         div_q   <= DIV_W'(2);
         cnt_q   <= '0;
         idx_q   <= '0;
         sel_q   <= 1'b0;
         clr_q   <= 1'b0;
         cfg_q   <= 1'b0;
         level_q <= 1'b0;
         irq_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         clr_q   <= clr_d;
         cfg_q   <= cfg_d;
         level_q <= level_d;
         irq_q   <= irq_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (is_start && state_q == STOPPED) state_d = PLAYING;
         if (is_stop && state_q == PLAYING)  state_d = STOPPED;
      end
   end

   // Tick/buffer update first; an accepted command then overrides, so a STOP
   // on a tick cycle keeps the swap but clears the index and counter.
   always_comb begin
      wait_d  = busy ? wait_q - WAIT_W'(1) : wait_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      clr_d   = 1'b0;
      cfg_d   = 1'b0;
      level_d = 1'b0;
      irq_d   = 1'b0;
      err_d   = 1'b0;

      if (state_q == PLAYING) begin
         if (tick) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(AUDIO_BUFFER_SIZE - 1)) begin
               idx_d = '0;
               sel_d = ~sel_q;
               irq_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end

      if (accept) begin
         if (!legal) begin
            err_d = 1'b1;
         end else if (is_clr || is_cfg) begin
            if (state_q == STOPPED) begin
               clr_d  = is_clr;
               cfg_d  = is_cfg;
               wait_d = WAIT_W'(CMD_WAIT_STATES);
               if (is_clr) begin
                  sel_d = 1'b0;
                  idx_d = '0;
               end
            end else begin
               err_d = 1'b1;
            end
         end else if (is_level) begin
            level_d = 1'b1;
            wait_d  = WAIT_W'(CMD_WAIT_STATES);
         end else if (is_start && state_q == STOPPED) begin
            div_d = (clk_div_in < DIV_W'(2)) ? DIV_W'(2) : clk_div_in;
            cnt_d = '0;
            idx_d = '0;
            sel_d = 1'b0;
         end else if (is_stop && state_q == PLAYING) begin
            cnt_d = '0;
            idx_d = '0;
         end
      end
   end

   always_comb begin
      cmd_ready_out = !busy;
      play_out      = (state_q == PLAYING);
      tick_out      = tick;
      clr_out       = clr_q;
      cfg_out       = cfg_q;
      level_out     = level_q;
      abuf_sel_out  = sel_q;
      abuf_idx_out  = idx_q;
      irq_out       = irq_q;
      cmd_err_out   = err_q;
   end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed self-checking bench for cmd_sequencer: strobe expectations and
// tick times are queued when stimulus is driven and popped as the DUT responds.
module tb_cmd_sequencer;

   localparam int WAITS = 25;
   localparam int ABS   = 42;
   localparam int DW    = 32;
   localparam int IW    = $clog2(ABS);

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid_in;
   logic [7:0]    cmd_in;
   logic          cmd_ready_out;
   logic [DW-1:0] clk_div_in;
   logic          play_out, tick_out, clr_out, cfg_out, level_out;
   logic          abuf_sel_out, irq_out, cmd_err_out;
   logic [IW-1:0] abuf_idx_out;
   logic [3:0]    strb;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t expQ[$];
   int   tickQ[$];

   cmd_sequencer #(.CMD_WAIT_STATES(WAITS), .AUDIO_BUFFER_SIZE(ABS), .DIV_W(DW)) dut (
      .clk(clk), .rst(rst), .cmd_valid_in(cmd_valid_in), .cmd_in(cmd_in),
      .cmd_ready_out(cmd_ready_out), .clk_div_in(clk_div_in), .play_out(play_out),
      .tick_out(tick_out), .clr_out(clr_out), .cfg_out(cfg_out), .level_out(level_out),
      .abuf_sel_out(abuf_sel_out), .abuf_idx_out(abuf_idx_out), .irq_out(irq_out),
      .cmd_err_out(cmd_err_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign strb = {clr_out, cfg_out, level_out, cmd_err_out};

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pushExp(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] obs);
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard-empty: observed=%0d expected=none", obs);
      end else begin
         e = expQ.pop_front();
         checkValue(e.tag, obs, e.val);
      end
   endtask

   // Offers one command at a negedge with ready high; checks {clr,cfg,level,err} next cycle.
   task automatic applyStimulus(input logic [7:0] code, input logic [3:0] expStrb, input string tag);
      pushExp(tag, 32'(expStrb));
      cmd_valid_in = 1'b1;
      cmd_in       = code;
      @(negedge clk);
      cmd_valid_in = 1'b0;
      cmd_in       = 8'h00;
      checkOutput(32'(strb));
   endtask

   task automatic checkResetState(input string tag);
      checkValue(tag, 32'({play_out, tick_out, clr_out, cfg_out, level_out, abuf_sel_out,
                           irq_out, cmd_err_out, cmd_ready_out, abuf_idx_out}),
                 32'({9'b000000001, 6'd0}));
   endtask

   task automatic waitReady(input int bound);
      for (int i = 0; i < bound && !cmd_ready_out; i++) @(negedge clk);
      checkValue("ready-wait", 32'(cmd_ready_out), 1);
   endtask

   task automatic waitTick(input int bound, output int at);
      @(negedge clk);
      for (int i = 0; i < bound && !tick_out; i++) @(negedge clk);
      if (!tick_out) checkValue("tick-wait", 32'(tick_out), 1);
      at = cyc;
   endtask

   initial begin
      int busyCycles, cfgEarly, clrExtra, playCyc, t, t2, lastTick, spacingBad, lateTicks;
      rst = 1'b1;
      cmd_valid_in = 1'b0;
      cmd_in = 8'h00;
      clk_div_in = '0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;
      @(negedge clk);

      // CLR, then CFG held off for the whole wait window
      cmd_valid_in = 1'b1;
      cmd_in = 8'h01;
      @(negedge clk);
      checkValue("clr-strobe", 32'(clr_out), 1);
      checkValue("clr-ready-low", 32'(cmd_ready_out), 0);
      cmd_in = 8'h02;
      busyCycles = 1;
      cfgEarly = 0;
      clrExtra = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready_out) break;
         busyCycles++;
         if (cfg_out) cfgEarly++;
         if (clr_out) clrExtra++;
      end
      checkValue("busy-cycles", busyCycles, WAITS);
      checkValue("cfg-held", cfgEarly, 0);
      checkValue("clr-single", clrExtra, 0);
      @(negedge clk);
      cmd_valid_in = 1'b0;
      cmd_in = 8'h00;
      checkValue("cfg-after-wait", 32'(cfg_out), 1);
      checkValue("cfg-ready-low", 32'(cmd_ready_out), 0);
      waitReady(40);

      // START at divider 60: tick in every 60th playing cycle, swap after 42
      clk_div_in = 60;
      applyStimulus(8'h04, 4'b0000, "start-60");
      checkValue("play-rise", 32'(play_out), 1);
      playCyc = cyc;
      for (int k = 0; k < ABS; k++) tickQ.push_back(playCyc + 59 + 60 * k);
      clk_div_in = 5;
      t = 0;
      for (int k = 0; k < ABS; k++) begin
         waitTick(70, t);
         if (tickQ.size() > 0) checkValue($sformatf("tick-time-%0d", k), t, tickQ.pop_front());
      end
      checkValue("idx-before-swap", 32'(abuf_idx_out), ABS - 1);
      checkValue("sel-before-swap", 32'(abuf_sel_out), 0);
      lastTick = t;
      @(negedge clk);
      checkValue("swap-sel", 32'(abuf_sel_out), 1);
      checkValue("swap-idx", 32'(abuf_idx_out), 0);
      checkValue("swap-irq", 32'(irq_out), 1);
      @(negedge clk);
      checkValue("irq-single", 32'(irq_out), 0);

      // CLR while playing is an error; LEVEL busy window spans a tick
      applyStimulus(8'h01, 4'b0001, "clr-in-play");
      checkValue("ready-after-clr-in-play", 32'(cmd_ready_out), 1);
      while (cyc < lastTick + 50) @(negedge clk);
      applyStimulus(8'h10, 4'b0010, "level-in-play");
      waitTick(70, t);
      checkValue("tick-in-busy-time", t, lastTick + 60);
      checkValue("tick-in-busy-ready", 32'(cmd_ready_out), 0);
      waitReady(40);
      applyStimulus(8'h08, 4'b0000, "stop");
      checkValue("stop-play", 32'(play_out), 0);
      checkValue("stop-idx", 32'(abuf_idx_out), 0);
      checkValue("stop-sel-kept", 32'(abuf_sel_out), 1);

      // START with divider 0 runs at 2; STOP on the 42nd tick keeps its swap
      clk_div_in = 0;
      applyStimulus(8'h04, 4'b0000, "start-0");
      checkValue("start-sel-clear", 32'(abuf_sel_out), 0);
      playCyc = cyc;
      waitTick(10, t);
      checkValue("div0-first-tick", t, playCyc + 1);
      spacingBad = 0;
      for (int k = 1; k < ABS; k++) begin
         waitTick(10, t2);
         if (t2 != t + 2) spacingBad++;
         t = t2;
      end
      checkValue("div0-spacing", spacingBad, 0);
      checkValue("div0-idx-last", 32'(abuf_idx_out), ABS - 1);
      cmd_valid_in = 1'b1;
      cmd_in = 8'h08;
      @(negedge clk);
      cmd_valid_in = 1'b0;
      cmd_in = 8'h00;
      checkValue("tickstop-play", 32'(play_out), 0);
      checkValue("tickstop-sel", 32'(abuf_sel_out), 1);
      checkValue("tickstop-idx", 32'(abuf_idx_out), 0);
      checkValue("tickstop-irq", 32'(irq_out), 1);
      lateTicks = 0;
      for (int i = 0; i < 10; i++) begin
         if (tick_out) lateTicks++;
         @(negedge clk);
      end
      checkValue("no-ticks-after-stop", lateTicks, 0);

      // Illegal codes
      applyStimulus(8'h03, 4'b0001, "illegal-03");
      applyStimulus(8'h20, 4'b0001, "illegal-20");
      checkValue("illegal-state", 32'({play_out, abuf_sel_out, cmd_ready_out}), 32'(3'b011));

      // Reset mid-wait and mid-play
      applyStimulus(8'h02, 4'b0100, "cfg-before-rst");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkResetState("rst-mid-wait");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clk_div_in = 4;
      applyStimulus(8'h04, 4'b0000, "start-4");
      waitTick(10, t);
      rst = 1'b1;
      #1;
      checkResetState("rst-mid-play");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clk_div_in = 3;
      applyStimulus(8'h04, 4'b0000, "start-3");
      checkValue("play-after-rst", 32'(play_out), 1);
      playCyc = cyc;
      waitTick(10, t);
      checkValue("div3-first-tick", t, playCyc + 2);
      waitTick(10, t2);
      checkValue("div3-second-tick", t2, t + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Command and playback sequencer for the audioport.
- Accepts one-hot command codes decoded from CMD_REG and issues single-cycle clr/cfg/level strobes to the cross-domain path, holding off further commands for a fixed wait-state window.
- Runs the play/stop state and the per-sample tick generator.
- Sequences the ABUF0/ABUF1 double buffer: read index, active-half select and an interrupt on each half swap.

Parameters:
- CMD_WAIT_STATES, 25, clk cycles busy after a CLR/CFG/LEVEL strobe.
- AUDIO_BUFFER_SIZE, 42, stereo samples per ABUF half.
- DIV_W, 32, width of the clock divider ratio.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid_in  in  1  command present
- cmd_in  in  8  command code: NOP 00, CLR 01, CFG 02, START 04, STOP 08, LEVEL 10
- cmd_ready_out  out  1  sequencer can accept a command
- clk_div_in  in  DIV_W  clk cycles per sample for the configured rate
- play_out  out  1  playback active
- tick_out  out  1  one-cycle sample request
- clr_out  out  1  one-cycle clear strobe
- cfg_out  out  1  one-cycle config-transfer strobe
- level_out  out  1  one-cycle level-transfer strobe
- abuf_sel_out  out  1  ABUF half being read (0 = ABUF0)
- abuf_idx_out  out  $clog2(AUDIO_BUFFER_SIZE)  sample index within the active half
- irq_out  out  1  one-cycle buffer-swap interrupt
- cmd_err_out  out  1  one-cycle illegal-command flag

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0 except cmd_ready_out=1. Internal counters are 0. play state is STOPPED.
- Handshake: a command is accepted on a rising edge when cmd_valid_in and cmd_ready_out are both 1. cmd_ready_out = !busy.
- Wait counter: on accepting CLR, CFG or LEVEL, the wait counter loads CMD_WAIT_STATES and busy rises on the next cycle.
  - The counter decrements each cycle.
  - busy falls when it reaches 0, giving exactly CMD_WAIT_STATES cycles with cmd_ready_out=0.
- Strobes: clr_out, cfg_out and level_out are registered, high for exactly the one cycle after acceptance.
- Play state machine, STOPPED/PLAYING:
  - START in STOPPED: latch the divider as div_r = max(clk_div_in, 2); play_out=1 next cycle; tick counter, abuf_idx and abuf_sel all set to 0.
  - STOP in PLAYING: play_out=0 next cycle; tick counter and abuf_idx cleared; abuf_sel retained.
  - START in PLAYING and STOP in STOPPED: accepted, no effect.
- Command legality:
  - CLR and CFG are legal only in STOPPED. In PLAYING they are accepted but ignored: no strobe, no wait, and cmd_err_out=1 for one cycle.
  - LEVEL is legal in both states.
  - Any non-one-hot code other than 00, or any code with bits [7:5] set: accepted, ignored, cmd_err_out pulse.
  - NOP: accepted, no effect.
- CLR additionally resets abuf_sel and abuf_idx to 0.
- Tick generator:
  - In PLAYING, the counter runs 0..div_r-1 and wraps.
  - tick_out = PLAYING && cnt == div_r-1 (decoded from registers, no input path).
  - The first tick comes div_r cycles after play_out rises; ticks repeat every div_r cycles.
  - Ticks continue while busy.
  - clk_div_in changes take effect only at the next START.
- Buffer sequencing:
  - On each tick, abuf_idx increments.
  - When a tick arrives with abuf_idx == AUDIO_BUFFER_SIZE-1, abuf_idx wraps to 0, abuf_sel toggles and irq_out pulses on the next cycle.
- Simultaneous events:
  - STOP accepted on a tick cycle: that tick is visible and its index/swap update is applied. No further ticks follow.
  - LEVEL accepted on a tick cycle: both actions occur.
- Reset mid-wait or mid-play returns immediately to the reset state; no strobe or irq is emitted after rst asserts.

Test Plan:
- Reset then CLR: clr_out high one cycle; cmd_ready_out low exactly 25 cycles; a CFG offered during that window is held until ready, then cfg_out pulses.
- CFG, then START with clk_div_in=60: first tick_out 60 cycles after play_out rises, then every 60 cycles; after the 42nd tick, abuf_sel=1, abuf_idx=0, irq_out pulses once.
- While PLAYING, send CLR: cmd_err_out pulses; no clr_out; cmd_ready_out stays 1; tick spacing unchanged. Send LEVEL: level_out pulses and ticks continue during the 25-cycle busy window.
- START with clk_div_in=0: ticks every 2 cycles. Then STOP on a tick cycle: that tick is counted, play_out falls, no further ticks; abuf_idx=0, abuf_sel retained.
- Illegal code 8'h03 and 8'h20: cmd_err_out pulses each time; no state change.
- Assert rst during a wait and during play: all outputs 0 and cmd_ready_out=1 immediately; a subsequent START plays normally.
